// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer time-sharing one external ALU between two requesters.
// Define ALU_SHARE_FIXED_PRIO_EN to make requester 0 always win a tie instead of round-robin.
module alu_share_arb #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*WIDTH-1:0]    req_a,
    input  logic [2*WIDTH-1:0]    req_b,
    input  logic [2*CTRL_W-1:0]   req_ctrl,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [CTRL_W-1:0]     alu_ctrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [3:0]            alu_flags,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the source holds valid and payload stable until then, and ready never
    // depends on a ready of the same channel.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic [WIDTH-1:0]    alu_a_q, alu_a_d;
    logic [WIDTH-1:0]    alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;

    logic                tie_pick;
    logic                grant_id;
    logic                grant_vld;
    logic                accept;
    logic                rsp_done;

    // Grant selection; only meaningful while idle.
    always_comb begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        tie_pick = 1'b0;
`else
        tie_pick = ~last_q;
`endif
        grant_id  = 1'b0;
        grant_vld = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_id  = 1'b0;
                grant_vld = 1'b1;
            end
            2'b10: begin
                grant_id  = 1'b1;
                grant_vld = 1'b1;
            end
            2'b11: begin
                grant_id  = tie_pick;
                grant_vld = 1'b1;
            end
            default: begin
                grant_id  = 1'b0;
                grant_vld = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / control decode; ready is forced low while reset is asserted.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == ST_IDLE) && rst && grant_vld) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
        accept   = |(req_valid & req_ready);
        rsp_done = (state_q == ST_RESP) && rsp_ready[gnt_q];
    end

    // Datapath next values
    always_comb begin
        gnt_d        = gnt_q;
        last_d       = last_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_valid_d  = rsp_valid_q;
        if (accept) begin
            gnt_d      = grant_id;
            alu_a_d    = grant_id ? req_a[2*WIDTH-1:WIDTH]    : req_a[WIDTH-1:0];
            alu_b_d    = grant_id ? req_b[2*WIDTH-1:WIDTH]    : req_b[WIDTH-1:0];
            alu_ctrl_d = grant_id ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
        end
        if (state_q == ST_EXEC) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_valid_d  = gnt_q ? 2'b10 : 2'b01;
        end
        if (rsp_done) begin
            rsp_valid_d = 2'b00;
            last_d      = gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_valid_q  <= 2'b00;
        end else begin
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_valid  = rsp_valid_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed and random checks of alu_share_arb against a behavioural ALU and a response scoreboard.
module tb_alu_share_arb;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_ctrl;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [36:0] exp_q[$];
    logic        acc_id[$];
    int          acc_cyc[$];
    logic [36:0] sb_e;

    alu_share_arb #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctrl   (req_ctrl),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // behavioural ALU, returns {V,C,N,Z,result}
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        v;
        logic        cy;
        s  = '0;
        r  = '0;
        v  = 1'b0;
        cy = 1'b0;
        case (c)
            3'd0: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                v  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cy = s[32];
                v  = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            default: r = '0;
        endcase
        return {v, cy, r[31], (r == 32'd0), r};
    endfunction

    always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: push on request accept, pop on response handshake
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({(i == 1),
                                     alu_fn(req_a[i*32 +: 32], req_b[i*32 +: 32], req_ctrl[i*3 +: 3])});
                    acc_id.push_back(i == 1);
                    acc_cyc.push_back(cyc);
                end
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", exp_q.size(), 1);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_rsp_owner", {30'd0, rsp_valid}, sb_e[36] ? 32'd2 : 32'd1);
                    chk("sb_rsp_result", rsp_result, sb_e[31:0]);
                    chk("sb_rsp_flags", {28'd0, rsp_flags}, {28'd0, sb_e[35:32]});
                end
            end
        end
    end

    // driver tasks (called at #1 after a rising edge)
    task automatic wait_accept(input int n);
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (acc_id.size() > n) break;
        end
        chk("accept_timeout", (acc_id.size() > n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_ctrl[id*3 +: 3] = c;
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
        int n;
        set_req(id, a, b, c);
        req_valid[id] = 1'b1;
        n = acc_id.size();
        wait_accept(n);
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int n0;
        logic exp_id;
        rst       = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_ctrl  = '0;
        rsp_ready = 2'b00;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", {28'd0, rsp_flags}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 0);
        req_valid = 2'b00;
        rst       = 1'b1;
        rsp_ready = 2'b11;
        @(posedge clk);
        #1;

        // single add
        send(0, 32'd5, 32'd3, 3'd0);
        chk("add_alu_a", alu_a, 5);
        chk("add_alu_b", alu_b, 3);
        chk("add_alu_ctrl", {29'd0, alu_ctrl}, 0);
        chk("add_exec_no_rsp", {30'd0, rsp_valid}, 0);
        @(posedge clk);
        #1;
        chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
        chk("add_result", rsp_result, 32'd8);
        chk("add_flags", {28'd0, rsp_flags}, 32'h0);
        @(posedge clk);
        #1;
        chk("add_done", {30'd0, rsp_valid}, 0);

        // sub overflow from requester 1
        send(1, 32'h8000_0000, 32'd1, 3'd1);
        @(posedge clk);
        #1;
        chk("sub_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("sub_result", rsp_result, 32'h7FFF_FFFF);
        chk("sub_flags", {28'd0, rsp_flags}, 32'hC);
        drain();

        // tie fairness, both requesters valid continuously
        set_req(0, 32'd10, 32'd4, 3'd1);
        set_req(1, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd2);
        n0 = acc_id.size();
        req_valid = 2'b11;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            #1;
            if (acc_id.size() >= n0 + 4) break;
        end
        req_valid = 2'b00;
        chk("tie_accepts", acc_id.size() - n0, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (k % 2) == 1;
`endif
            if (acc_id.size() > n0 + k) begin
                chk("tie_grant", {31'd0, acc_id[n0+k]}, {31'd0, exp_id});
                if (k > 0) chk("tie_interval", acc_cyc[n0+k] - acc_cyc[n0+k-1], 3);
            end
        end
        drain();

        // back-pressure with requester 1 waiting, plus non-owner ready
        rsp_ready = 2'b00;
        send(0, 32'hFFFF_FFFF, 32'd1, 3'd0);
        set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'd3);
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < 5; t++) begin
            chk("bp_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'd0);
            chk("bp_flags", {28'd0, rsp_flags}, 32'h5);
            chk("bp_req_ready", {30'd0, req_ready}, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 2'b10;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk);
            #1;
            chk("nonowner_rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("nonowner_state", {30'd0, dbg_state}, 32'd2);
            chk("nonowner_req_ready", {30'd0, req_ready}, 0);
        end
        rsp_ready = 2'b01;
        n0 = acc_id.size();
        @(posedge clk);
        #1;
        chk("bp_released", {30'd0, rsp_valid}, 0);
        chk("bp_waiter_ready", {30'd0, req_ready}, 32'd2);
        wait_accept(n0);
        req_valid = 2'b00;
        if (acc_id.size() > n0) chk("bp_waiter_id", {31'd0, acc_id[n0]}, 32'd1);
        rsp_ready = 2'b11;
        @(posedge clk);
        #1;
        chk("or_rsp_valid", {30'd0, rsp_valid}, 32'd2);
        chk("or_result", rsp_result, 32'hFF);
        drain();

        // reset during EXEC, request kept pending
        set_req(0, 32'd7, 32'd9, 3'd0);
        req_valid = 2'b01;
        n0 = acc_id.size();
        wait_accept(n0);
        chk("mid_in_exec", {30'd0, dbg_state}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("mid_req_ready", {30'd0, req_ready}, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_alu_b", alu_b, 0);
        chk("mid_rsp_result", rsp_result, 0);
        chk("mid_rsp_flags", {28'd0, rsp_flags}, 0);
        chk("mid_state", {30'd0, dbg_state}, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        n0 = acc_id.size();
        wait_accept(n0);
        req_valid = 2'b00;
        chk("mid_no_stale", {30'd0, rsp_valid}, 0);
        chk("mid_reaccept_a", alu_a, 7);
        @(posedge clk);
        #1;
        chk("mid_rsp", {30'd0, rsp_valid}, 32'd1);
        chk("mid_result", rsp_result, 32'd16);
        drain();

        // random traffic through the scoreboard
        for (int r = 0; r < 10; r++) begin
            send($urandom_range(0, 1), $urandom, $urandom, 3'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();

        chk("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer that time-shares one 32-bit ALU (add/sub/and/or with V/C/N/Z flags) between two clients, e.g. the integer execute path and an address-generation/debug client. Each client issues operand/opcode requests over a valid/ready channel and gets result and flags back over a separate valid/ready response channel. The block drives the ALU from registered operands and captures its combinational result one cycle later. Requesters are granted round-robin.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- CTRL_W, 3, ALU control width; must match the ALU.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accept.
- req_a  in  2*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH].
- req_b  in  2*WIDTH  operand B, same packing.
- req_ctrl  in  2*CTRL_W  ALU control (000 add, 001 sub, 010 and, 011 or), same packing.
- rsp_valid  out  2  per-requester response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_result  out  WIDTH  captured ALU result; shared, qualified by rsp_valid.
- rsp_flags  out  4  captured {V,C,N,Z}; shared, qualified by rsp_valid.
- alu_a, alu_b  out  WIDTH  registered operands to the ALU.
- alu_ctrl  out  CTRL_W  registered control to the ALU.
- alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl.
- alu_flags  in  4  ALU {V,C,N,Z}.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: state, gnt (1 bit, owner of current op), last (1 bit, last requester served), operand/ctrl regs, result/flag regs.
- Grant (combinational, IDLE only): if exactly one req_valid bit set, grant it. If both are set, grant ~last.
- req_ready[i] = (state==IDLE) && granted==i. At most one bit is high. In any other state it is 0.
- IDLE -> EXEC on accept: latch the granted requester's a/b/ctrl into alu_a/alu_b/alu_ctrl, set gnt.
- EXEC -> RESP unconditionally: capture alu_result and alu_flags into rsp_result/rsp_flags.
- RESP: rsp_valid[gnt]=1, other bit 0. When rsp_ready[gnt]=1: last<=gnt, go to IDLE. rsp_ready of the non-owner is ignored.
- Ctrl is forwarded unmodified. Codes 1xx are passed through and behave as the ALU defines.
- No request is accepted while an op is in flight, and requests are never dropped. The requester must hold valid and payload stable until ready.
- Reset (asynchronous, any state): state=IDLE, last=1 (requester 0 wins the first tie). req_ready=0 is held only while rst is low. rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_ctrl=0, gnt=0. An in-flight op is discarded with no response.

## Timing
- Accept at edge k (valid&&ready sampled high).
- alu_* drive the new operands from k. Result is captured at edge k+1.
- rsp_valid is high from edge k+1 until the handshake edge, with rsp_result/rsp_flags stable meanwhile.
- Minimum issue interval is 3 cycles: with rsp_ready tied high, accepts occur at k, k+3, k+6, …
- req_ready is combinational from req_valid and state (no ready-to-valid dependency). All other outputs are registered.
- Back-pressure: rsp_ready low holds RESP indefinitely. The other requester waits.

## Configuration
- ALU_SHARE_FIXED_PRIO_EN defined: tie-break is fixed, and requester 0 always wins when both are valid. `last` is still maintained but unused.
- Not defined: round-robin tie-break via `last` as described above (default).

## Test plan
- Single add: reset, req_valid=01, a=5, b=3, ctrl=000 -> accept at k; rsp_valid=01 at k+1, result=8, flags=0000.
- Sub overflow: requester 1, a=0x80000000, b=1, ctrl=001 -> rsp_valid=10, result=0x7FFFFFFF, flags=1100.
- Tie fairness: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1 at k, k+3, k+6, k+9. With ALU_SHARE_FIXED_PRIO_EN -> requester 0 every time.
- Back-pressure: rsp_ready=00 for 5 cycles in RESP -> rsp_valid, result and flags stable. req_ready=00 throughout. Completes on the first cycle rsp_ready[gnt]=1.
- Reset mid-op: assert rst low during EXEC -> all outputs 0 immediately. After release, the pending request is re-accepted with no stale rsp_valid.
- Non-owner ready: rsp_ready=10 while gnt=0 in RESP -> stays in RESP, no state change.
